// File: rtl/envelope_follower.sv
// Envelope follower and gate detector: tracks |sample| with separate attack/release
// smoothing and derives a note gate with open/close hysteresis and a hold period.
module envelope_follower #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ATTACK_SHIFT  = 2,
    parameter int unsigned RELEASE_SHIFT = 6,
    parameter int unsigned OPEN_THRESH   = 4096,
    parameter int unsigned CLOSE_THRESH  = 2048,
    parameter int unsigned HOLD_SAMPLES  = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] envelope_o,
    output logic                  gate_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned ENV_W     = DATA_WIDTH - 1;
    localparam int unsigned CNT_W     = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam int unsigned HOLD_LAST = (HOLD_SAMPLES > 0) ? HOLD_SAMPLES - 1 : 0;
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    typedef enum logic [1:0] {
        ST_CLOSED,
        ST_OPEN,
        ST_HOLD
    } gate_state_t;

    gate_state_t            state;
    gate_state_t            state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [ENV_W-1:0]       env;
    logic [ENV_W-1:0]       env_next;
    logic [DATA_WIDTH-1:0]  mag_full;
    logic [ENV_W-1:0]       target;
    logic [ENV_W-1:0]       diff;
    logic [ENV_W-1:0]       shifted;
    logic [ENV_W-1:0]       step;
    logic                   rise;
    logic                   open_hit;
    logic                   close_hit;
    logic                   accept;

    // Handshake: the single output register frees up when it is empty or being drained.
    assign ready_o    = !valid_o || ready_i;
    assign accept     = valid_i && ready_o;
    assign envelope_o = {1'b0, env};

    // Saturated magnitude and attack/release step toward it; step never exceeds diff.
    always_comb begin
        mag_full = sample_i[DATA_WIDTH-1] ? (~sample_i + DATA_WIDTH'(1)) : sample_i;
        target   = mag_full[DATA_WIDTH-1] ? ENV_MAX : mag_full[ENV_W-1:0];
        rise     = target > env;
        diff     = rise ? (target - env) : (env - target);
        shifted  = rise ? (diff >> ATTACK_SHIFT) : (diff >> RELEASE_SHIFT);
        step     = shifted;
        if (shifted == '0 && diff != '0) begin
            step = ENV_W'(1);
        end
        env_next  = rise ? (env + step) : (env - step);
        open_hit  = {1'b0, env_next} >= DATA_WIDTH'(OPEN_THRESH);
        close_hit = {1'b0, env_next} <  DATA_WIDTH'(CLOSE_THRESH);
    end

    // Gate transitions evaluated on the envelope this sample will produce.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_CLOSED: begin
                if (open_hit) begin
                    state_next = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (close_hit) begin
                    cnt_next   = '0;
                    state_next = (HOLD_SAMPLES == 0) ? ST_CLOSED : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (open_hit) begin
                    state_next = ST_OPEN;
                end else if (cnt == CNT_W'(HOLD_LAST)) begin
                    state_next = ST_CLOSED;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_CLOSED;
            end
        endcase
    end

    // State only advances on accepted samples; gate and envelope update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            env     <= '0;
            state   <= ST_CLOSED;
            cnt     <= '0;
            gate_o  <= 1'b0;
            valid_o <= 1'b0;
        end else if (accept) begin
            env     <= env_next;
            state   <= state_next;
            cnt     <= cnt_next;
            gate_o  <= (state_next != ST_CLOSED);
            valid_o <= 1'b1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// Self-checking bench for envelope_follower: vector table plus scoreboarded sequences.
module tb_envelope_follower;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] sample_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] envelope_o;
    logic        gate_o;
    logic        valid_o;
    logic        ready_i;

    envelope_follower dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sample_i   (sample_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .envelope_o (envelope_o),
        .gate_o     (gate_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit do_rst;
        int sample;
        int exp_env;
        bit exp_gate;
    } vec_t;

    typedef struct {
        int env;
        bit gate;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_env    = 0;
    int   m_state  = 0;
    int   m_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model in plain integer arithmetic (0=closed, 1=open, 2=hold).
    task automatic model_step(input int s, output exp_t e);
        int t;
        int d;
        int st;
        t = (s < 0) ? -s : s;
        if (t > 32767) t = 32767;
        if (t > m_env) begin
            d = t - m_env; st = d / 4; if (st == 0) st = 1; m_env += st;
        end else if (t < m_env) begin
            d = m_env - t; st = d / 64; if (st == 0) st = 1; m_env -= st;
        end
        case (m_state)
            0: if (m_env >= 4096) m_state = 1;
            1: if (m_env < 2048) begin m_state = 2; m_cnt = 0; end
            default: begin
                if (m_env >= 4096) m_state = 1;
                else if (m_cnt == 63) m_state = 0;
                else m_cnt++;
            end
        endcase
        e.env  = m_env;
        e.gate = (m_state != 0);
    endtask

    // Present one sample, wait (bounded) for it to be accepted, queue its expectation.
    task automatic send_exp(input int s, input exp_t e);
        bit acc;
        int budget;
        acc = 0;
        budget = 0;
        valid_i  = 1'b1;
        sample_i = 16'(s);
        while (!acc && budget < 100) begin
            @(negedge clk_i);
            if (ready_o === 1'b1) acc = 1;
            @(posedge clk_i);
            #1;
            budget++;
        end
        valid_i = 1'b0;
        if (acc) begin
            sb.push_back(e);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: sample %0d not accepted within %0d cycles", s, budget);
        end
    endtask

    task automatic send(input int s);
        exp_t e;
        model_step(s, e);
        send_exp(s, e);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 50) begin
            @(posedge clk_i);
            #1;
            b++;
        end
        check("drain_queue_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        sample_i = '0;
        ready_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        sb.delete();
        m_env   = 0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    task automatic settle_16000();
        for (int i = 0; i < 200 && m_env != 16000; i++) send(16000);
        check("settle_env", int'(envelope_o), 16000);
    endtask

    // Output monitor: every transfer is compared against the scoreboard head.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: env %0d gate %0d with empty scoreboard",
                         envelope_o, gate_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_envelope", int'(envelope_o), e.env);
                check("sb_gate", int'(gate_o), int'(e.gate));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        exp_t e;
        exp_t em;
        int   first;
        int   drop;
        int   gate_at_first;
        int   dropped;
        int   env_hold;
        int   gate_hold;

        vecs[0] = '{1,  16000,  4000, 0};
        vecs[1] = '{0,  16000,  7000, 1};
        vecs[2] = '{0,  16000,  9250, 1};
        vecs[3] = '{0,  16000, 10937, 1};
        vecs[4] = '{1, -16000,  4000, 0};
        vecs[5] = '{0, -16000,  7000, 1};
        vecs[6] = '{1, -32768,  8191, 1};
        vecs[7] = '{0,      0,  8064, 1};
        vecs[8] = '{0,  32767, 14239, 1};

        // Reset state, then an asynchronous reset while an output is pending.
        do_reset();
        check("rst_envelope", int'(envelope_o), 0);
        check("rst_valid", int'(valid_o), 0);
        send(1000);
        check("pre_rst_valid", int'(valid_o), 1);
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_envelope", int'(envelope_o), 0);
        check("async_rst_gate", int'(gate_o), 0);
        check("async_rst_valid", int'(valid_o), 0);
        check("async_rst_ready", int'(ready_o), 1);
        do_reset();

        // Table: attack sequence, negative input symmetry, saturation, release step.
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_rst) begin
                drain();
                do_reset();
            end
            model_step(vecs[i].sample, em);
            e.env  = vecs[i].exp_env;
            e.gate = vecs[i].exp_gate;
            send_exp(vecs[i].sample, e);
        end
        drain();

        // Attack converges exactly, then release to zero with a 64-sample hold.
        do_reset();
        settle_16000();
        first = -1;
        drop = -1;
        gate_at_first = 0;
        for (int i = 0; i < 2000; i++) begin
            send(0);
            if (first < 0 && envelope_o < 16'd2048) begin
                first = i;
                gate_at_first = int'(gate_o);
            end
            if (first >= 0 && drop < 0 && gate_o == 1'b0) drop = i;
            if (drop >= 0 && envelope_o == 16'd0) break;
        end
        check("hold_gate_at_close", gate_at_first, 1);
        check("hold_length", drop - first, 64);
        check("release_reaches_zero", int'(envelope_o), 0);
        drain();

        // Retrigger from HOLD: the gate must never drop.
        do_reset();
        settle_16000();
        dropped = 0;
        for (int i = 0; i < 1000 && envelope_o >= 16'd2048; i++) begin
            send(0);
            if (gate_o == 1'b0) dropped = 1;
        end
        for (int i = 0; i < 10; i++) begin
            send(0);
            if (gate_o == 1'b0) dropped = 1;
        end
        send(32767);
        check("retrigger_gate", int'(gate_o), 1);
        if (gate_o == 1'b0) dropped = 1;
        for (int i = 0; i < 70; i++) begin
            send(0);
            if (gate_o == 1'b0) dropped = 1;
        end
        check("retrigger_never_dropped", dropped, 0);
        drain();

        // Backpressure: output frozen, nothing consumed, sequence resumes intact.
        do_reset();
        send(16000);
        send(16000);
        ready_i   = 1'b0;
        env_hold  = int'(envelope_o);
        gate_hold = int'(gate_o);
        valid_i   = 1'b1;
        sample_i  = 16'(16000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("bp_ready_low", int'(ready_o), 0);
            check("bp_envelope_stable", int'(envelope_o), env_hold);
            check("bp_gate_stable", int'(gate_o), gate_hold);
            @(posedge clk_i);
            #1;
        end
        check("bp_valid_held", int'(valid_o), 1);
        check("bp_env_value", env_hold, 7000);
        ready_i = 1'b1;
        send(16000);
        check("bp_resume_env", int'(envelope_o), 9250);
        send(16000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
